e_md_unit: RTL and testbench

// Execute-stage multiply/divide unit with HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/e_md_unit_if.sv | 27 ++
 rtl/e_md_unit.sv | 158 +++++++++++++++
 tb/tb_e_md_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/e_md_unit_if.sv
// Execute-stage multiply/divide bus: issue fields from E-stage control,
// plus the busy flag and architectural HI/LO returned to the datapath.
//
// Issue protocol: an op is taken on a rising clk edge when md_en is high,
// busy is low and the unit's intReq input is low. md_en is a one-cycle pulse
// per instruction. busy high means the unit will ignore md_en. The hazard
// unit stalls decode so that md_en is never raised while busy is high.
interface e_md_unit_if;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbgState;   // current sequencer state (0 = idle, 1 = run)

    modport master (
        output md_en, md_op, src_a, src_b,
        input  busy, hi, lo, dbgState
    );

    modport slave (
        input  md_en, md_op, src_a, src_b,
        output busy, hi, lo, dbgState
    );
endinterface

// File: rtl/e_md_unit.sv
// Multiply/divide unit with HI/LO. MULT/DIV results are computed at issue,
// held in a staging pair, and committed to HI/LO when the countdown expires,
// so software sees the architectural multi-cycle latency. MTHI/MTLO write
// directly in one cycle.
module e_md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      intReq,
    e_md_unit_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [31:0]   hiReg;
    logic [31:0]   loReg;
    logic [31:0]   stagedHi;
    logic [31:0]   stagedLo;
    logic          stagedWr;   // cleared for divide-by-zero so HI/LO keep their values

    logic          issue;
    logic [63:0]   sProd;
    logic [63:0]   uProd;
    logic [31:0]   absA;
    logic [31:0]   absB;
    logic [31:0]   magQ;
    logic [31:0]   magR;
    logic [31:0]   sQuot;
    logic [31:0]   sRem;
    logic [31:0]   uDivisor;
    logic [31:0]   uQuot;
    logic [31:0]   uRem;
    logic          divZero;
    logic [31:0]   nextHi;
    logic [31:0]   nextLo;
    logic          nextWr;
    logic          nextLong;
    logic [CW-1:0] nextCount;

    assign issue = md.md_en & ~intReq & (state == IDLE);

    // Result datapath: product and quotient/remainder for the op being offered.
    // Signed division works on magnitudes and restores signs afterwards, which
    // also yields 0x80000000 / -1 = 0x80000000 remainder 0 without a special case.
    always_comb begin
        sProd    = {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b};
        uProd    = {32'd0, md.src_a} * {32'd0, md.src_b};
        divZero  = (md.src_b == 32'd0);
        absA     = md.src_a[31] ? (~md.src_a + 32'd1) : md.src_a;
        absB     = md.src_b[31] ? (~md.src_b + 32'd1) : md.src_b;
        if (divZero) absB = 32'd1;
        magQ     = absA / absB;
        magR     = absA % absB;
        sQuot    = (md.src_a[31] ^ md.src_b[31]) ? (~magQ + 32'd1) : magQ;
        sRem     = md.src_a[31] ? (~magR + 32'd1) : magR;
        uDivisor = divZero ? 32'd1 : md.src_b;
        uQuot    = md.src_a / uDivisor;
        uRem     = md.src_a % uDivisor;

        nextHi    = 32'd0;
        nextLo    = 32'd0;
        nextWr    = 1'b0;
        nextLong  = 1'b0;
        nextCount = '0;
        case (md.md_op)
            OP_MULT: begin
                {nextHi, nextLo} = sProd;
                nextWr    = 1'b1;
                nextLong  = 1'b1;
                nextCount = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
                {nextHi, nextLo} = uProd;
                nextWr    = 1'b1;
                nextLong  = 1'b1;
                nextCount = CW'(MULT_CYCLES);
            end
            OP_DIV: begin
                nextHi    = sRem;
                nextLo    = sQuot;
                nextWr    = ~divZero;
                nextLong  = 1'b1;
                nextCount = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
                nextHi    = uRem;
                nextLo    = uQuot;
                nextWr    = ~divZero;
                nextLong  = 1'b1;
                nextCount = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // Sequencer: idle accepts ops; run counts down and commits staged results.
    // intReq only gates issue, so an op already running finishes regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            hiReg    <= 32'd0;
            loReg    <= 32'd0;
            stagedHi <= 32'd0;
            stagedLo <= 32'd0;
            stagedWr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (nextLong) begin
                            stagedHi <= nextHi;
                            stagedLo <= nextLo;
                            stagedWr <= nextWr;
                            counter  <= nextCount;
                            state    <= RUN;
                        end else if (md.md_op == OP_MTHI) begin
                            hiReg <= md.src_a;
                        end else if (md.md_op == OP_MTLO) begin
                            loReg <= md.src_a;
                        end
                    end
                end
                RUN: begin
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        state <= IDLE;
                        if (stagedWr) begin
                            hiReg <= stagedHi;
                            loReg <= stagedLo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.busy     = (state == RUN);
    assign md.hi       = hiReg;
    assign md.lo       = loReg;
    assign md.dbgState = state;

endmodule

// File: tb/tb_e_md_unit.sv
// Bench for e_md_unit: a table of directed ops with hand-derived results,
// hand-written reset and interrupt sequences, then random ops checked
// against an arithmetic model of HI/LO.
module tb_e_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    logic intReq;

    int nChecks = 0;
    int nFail   = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;

    e_md_unit_if mdIf ();

    e_md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .intReq (intReq),
        .md     (mdIf)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eHi;
        logic [31:0] eLo;
        int          eN;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one op in the current cycle (called #1 after a rising edge), then
    // count busy cycles, checking HI/LO hold their old values meanwhile.
    task automatic doOp(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic intr, input logic intMid,
                        input logic [31:0] eHi, input logic [31:0] eLo, input int eN);
        int n;
        check({nm, " idle before issue"}, 64'(mdIf.busy), 64'd0);
        mdIf.md_en = 1'b1;
        mdIf.md_op = op;
        mdIf.src_a = a;
        mdIf.src_b = b;
        intReq     = intr;
        @(posedge clk); #1;
        mdIf.md_en = 1'b0;
        mdIf.md_op = 3'($urandom);
        mdIf.src_a = $urandom;
        mdIf.src_b = $urandom;
        intReq     = intMid;
        n = 0;
        while (mdIf.busy === 1'b1 && n < 64) begin
            check({nm, " hi held"}, 64'(mdIf.hi), 64'(mHi));
            check({nm, " lo held"}, 64'(mdIf.lo), 64'(mLo));
            n++;
            @(posedge clk); #1;
            intReq = 1'b0;
        end
        intReq = 1'b0;
        check({nm, " busy cycles"}, 64'(n), 64'(eN));
        check({nm, " hi"}, 64'(mdIf.hi), 64'(eHi));
        check({nm, " lo"}, 64'(mdIf.lo), 64'(eLo));
        mHi = eHi;
        mLo = eLo;
    endtask

    // Random op, expected result from plain 64-bit arithmetic.
    task automatic doRandom(input int idx);
        logic [2:0]  op;
        logic [31:0] a, b, eHi, eLo;
        logic        intr, intMid;
        longint      sa, sb, p;
        logic [63:0] up;
        int          eN;
        op     = 3'($urandom_range(0, 7));
        a      = $urandom;
        case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1, 2:    b = 32'($urandom_range(1, 20));
            3:       b = -32'($urandom_range(1, 20));
            default: b = $urandom;
        endcase
        intr   = ($urandom_range(0, 7) == 0);
        intMid = ($urandom_range(0, 3) == 0);
        eHi = mHi;
        eLo = mLo;
        eN  = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (!intr) begin
            case (op)
                3'd1: begin p = sa * sb; {eHi, eLo} = p; eN = MC; end
                3'd2: begin up = {32'd0, a} * {32'd0, b}; {eHi, eLo} = up; eN = MC; end
                3'd3: begin
                    if (b != 0) begin eLo = 32'(sa / sb); eHi = 32'(sa % sb); end
                    eN = DC;
                end
                3'd4: begin
                    if (b != 0) begin eLo = a / b; eHi = a % b; end
                    eN = DC;
                end
                3'd5: eHi = a;
                3'd6: eLo = a;
                default: ;
            endcase
        end
        doOp($sformatf("rnd%0d op%0d", idx, op), op, a, b, intr, intMid, eHi, eLo, eN);
    endtask

    initial begin
        // directed vectors, applied in order; "unchanged" rows rely on the previous rows
        vecs[0]  = '{3'd5, 32'h00000011, 32'h0,        32'h00000011, 32'h00000000, 0};
        vecs[1]  = '{3'd6, 32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0};
        vecs[2]  = '{3'd3, 32'h00000005, 32'h0,        32'h00000011, 32'h00000022, DC};
        vecs[3]  = '{3'd4, 32'h00000009, 32'h0,        32'h00000011, 32'h00000022, DC};
        vecs[4]  = '{3'd1, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        vecs[5]  = '{3'd2, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, MC};
        vecs[6]  = '{3'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[7]  = '{3'd4, 32'h00000007, 32'h2,        32'h00000001, 32'h00000003, DC};
        vecs[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[9]  = '{3'd6, 32'h0000ABCD, 32'h0,        32'h00000000, 32'h0000ABCD, 0};
        vecs[10] = '{3'd0, 32'h12345678, 32'h9,        32'h00000000, 32'h0000ABCD, 0};
        vecs[11] = '{3'd7, 32'h12345678, 32'h9,        32'h00000000, 32'h0000ABCD, 0};
        vecs[12] = '{3'd4, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, DC};
        vecs[13] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[14] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};

        // reset
        reset       = 1'b1;
        intReq      = 1'b0;
        mdIf.md_en  = 1'b0;
        mdIf.md_op  = 3'd0;
        mdIf.src_a  = 32'd0;
        mdIf.src_b  = 32'd0;
        mHi = 32'd0;
        mLo = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", 64'(mdIf.busy), 64'd0);
        check("reset hi", 64'(mdIf.hi), 64'd0);
        check("reset lo", 64'(mdIf.lo), 64'd0);

        // directed table
        for (int i = 0; i < 15; i++)
            doOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
                 vecs[i].eHi, vecs[i].eLo, vecs[i].eN);

        // intReq cancels a same-cycle MULT and MTHI
        doOp("int cancels mult", 3'd1, 32'd3, 32'd4, 1'b1, 1'b0, mHi, mLo, 0);
        doOp("int cancels mthi", 3'd5, 32'hDEAD, 32'd0, 1'b1, 1'b0, mHi, mLo, 0);
        // intReq during busy leaves the running op alone; next one issues back-to-back
        doOp("int mid mult", 3'd1, 32'd6, 32'd7, 1'b0, 1'b1, 32'd0, 32'd42, MC);
        doOp("b2b multu", 3'd2, 32'd10, 32'd11, 1'b0, 1'b0, 32'd0, 32'd110, MC);
        doOp("mthi", 3'd5, 32'h55, 32'd0, 1'b0, 1'b0, 32'h55, 32'd110, 0);

        // reset in the 4th busy cycle of a DIV
        check("pre-div idle", 64'(mdIf.busy), 64'd0);
        mdIf.md_en = 1'b1;
        mdIf.md_op = 3'd3;
        mdIf.src_a = 32'd100;
        mdIf.src_b = 32'd7;
        @(posedge clk); #1;
        mdIf.md_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("div busy cycle 4", 64'(mdIf.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid-div reset busy", 64'(mdIf.busy), 64'd0);
        check("mid-div reset hi", 64'(mdIf.hi), 64'd0);
        check("mid-div reset lo", 64'(mdIf.lo), 64'd0);
        mHi = 32'd0;
        mLo = 32'd0;
        repeat (12) @(posedge clk);
        #1;
        check("post-reset hi stays", 64'(mdIf.hi), 64'd0);
        check("post-reset lo stays", 64'(mdIf.lo), 64'd0);

        // random ops against the model
        for (int i = 0; i < 60; i++)
            doRandom(i);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    // overall time guard
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, failures so far %0d", nFail);
        $fatal(1, "timeout");
    end

endmodule
